// File: rtl/vga_fb_pkg.sv
// Shared definitions for the framebuffer scanout engine: pixel modes,
// default geometry, the arbiter grant encoding and the colour unpackers.
package vga_fb_pkg;

    // Pixel formats selectable per frame
    localparam logic MODE_RGB332 = 1'b0;
    localparam logic MODE_RGB565 = 1'b1;

    // Default geometry and memory sizing
    localparam int DEF_H_ACTIVE   = 800;
    localparam int DEF_V_ACTIVE   = 600;
    localparam int DEF_ADDR_W     = 19;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int WORD_W         = 16;

    // 4-bit-per-channel colour as driven onto the DAC pins
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Owner of the single SRAM port in a given cycle
    typedef enum logic [1:0] {
        GRANT_NONE  = 2'd0,
        GRANT_READ  = 2'd1,
        GRANT_WRITE = 2'd2
    } grant_e;

    // Number of 16-bit words a full frame occupies in the given mode
    function automatic int frame_words(input logic mode, input int h, input int v);
        return (mode == MODE_RGB565) ? (h * v) : ((h * v) / 2);
    endfunction

    // RGB332 byte to 4:4:4; the top bit(s) are replicated into the low bits
    function automatic rgb444_t unpack_rgb332(input logic [7:0] px);
        rgb444_t c;
        c.r = {px[7:5], px[7]};
        c.g = {px[4:2], px[4]};
        c.b = {px[1:0], px[1:0]};
        return c;
    endfunction

    // RGB565 word to 4:4:4; keep the four most significant bits per channel
    function automatic rgb444_t unpack_rgb565(input logic [15:0] px);
        rgb444_t c;
        c.r = px[15:12];
        c.g = px[10:7];
        c.b = px[4:1];
        return c;
    endfunction

endpackage

// File: rtl/fb_prefetch_fifo.sv
// Show-ahead FIFO holding prefetched framebuffer words. The head word is
// visible combinationally whenever the FIFO is not empty; flush empties it
// in one cycle and takes priority over push and pop.
module fb_prefetch_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [PTR_W:0]   level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage write port
    // NOTE: storage is deliberately not reset; the pointers define which
    // entries are valid, and resetting an array would block RAM inference.
    // Sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; power-of-two depth wraps naturally
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer scanout engine. Streams the frame linearly out of SRAM into a
// prefetch FIFO, shares the SRAM port with a host write channel, and unpacks
// FIFO words into registered 4:4:4 pixels as the raster requests them.
module vga_fb_scanout
    import vga_fb_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_req,
    input  logic              mode,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic [1:0]        wr_be,
    output logic              sram_re,
    output logic              sram_we,
    output logic [1:0]        sram_be,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_wdata,
    input  logic [15:0]       sram_rdata,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              underrun
);

    localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
    localparam int WL_W      = $clog2(FRAME_PIX + 1);
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1;

    localparam logic [WL_W-1:0]  WORDS_565 = WL_W'(frame_words(MODE_RGB565, H_ACTIVE, V_ACTIVE));
    localparam logic [WL_W-1:0]  WORDS_332 = WL_W'(frame_words(MODE_RGB332, H_ACTIVE, V_ACTIVE));
    localparam logic [LVL_W-1:0] LVL_HALF  = LVL_W'(FIFO_DEPTH / 2);
    localparam logic [LVL_W:0]   LVL_FULL  = (LVL_W + 1)'(FIFO_DEPTH);

    // Frame-level read state
    logic              mode_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [WL_W-1:0]   words_left;
    logic              rd_pending;   // a read issued last cycle returns data now

    // FIFO interface
    logic              fifo_push;
    logic              fifo_pop;
    logic [WORD_W-1:0] fifo_head;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    logic [LVL_W:0]    occupancy;

    // Arbitration
    grant_e            grant;
    logic              rd_eligible;

    // Pixel path
    rgb444_t           pix_q;
    rgb444_t           pix_next;
    logic              byte_sel;     // 0: low byte next, 1: high byte next
    logic              byte_sel_next;
    logic              underrun_next;
    logic [7:0]        cur_byte;

    // Returning read data is dropped when a new frame starts in its cycle
    assign fifo_push = rd_pending && !frame_start;

    fb_prefetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (frame_start),
        .push      (fifo_push),
        .push_data (sram_rdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Count the word still in flight so the FIFO can never be overcommitted
    assign occupancy   = {1'b0, fifo_level} + {{LVL_W{1'b0}}, rd_pending};
    assign rd_eligible = !rst && !frame_start && (words_left != '0) && (occupancy < LVL_FULL);

    // Port arbiter: a draining FIFO outranks the host, otherwise host first
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant = GRANT_NONE;
        if (rd_eligible && (fifo_level < LVL_HALF)) begin
            grant = GRANT_READ;
        end else if (wr_valid && !rst) begin
            grant = GRANT_WRITE;
        end else if (rd_eligible) begin
            grant = GRANT_READ;
        end
    end

    // Drive the SRAM port from the grant; idle cycles leave everything at 0
    always_comb begin
        wr_ready   = 1'b0;
        sram_re    = 1'b0;
        sram_we    = 1'b0;
        sram_be    = 2'b00;
        sram_addr  = '0;
        sram_wdata = '0;
        case (grant)
            GRANT_READ: begin
                sram_re   = 1'b1;
                sram_be   = 2'b11;
                sram_addr = rd_addr;
            end
            GRANT_WRITE: begin
                wr_ready   = 1'b1;
                sram_we    = 1'b1;
                sram_be    = wr_be;
                sram_addr  = wr_addr;
                sram_wdata = wr_data;
            end
            default: ;
        endcase
    end

    // Frame setup, linear read address, remaining-word count, in-flight flag
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= MODE_RGB332;
            rd_addr    <= '0;
            words_left <= '0;
            rd_pending <= 1'b0;
        end else if (frame_start) begin
            mode_q     <= mode;
            rd_addr    <= fb_base;
            words_left <= (mode == MODE_RGB565) ? WORDS_565 : WORDS_332;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= (grant == GRANT_READ);
            if (grant == GRANT_READ) begin
                rd_addr    <= rd_addr + ADDR_W'(1);
                words_left <= words_left - WL_W'(1);
            end
        end
    end

    // Unpack the head word into the next pixel and decide when to pop
    always_comb begin
        pix_next      = '0;
        fifo_pop      = 1'b0;
        byte_sel_next = byte_sel;
        underrun_next = underrun;
        cur_byte      = byte_sel ? fifo_head[15:8] : fifo_head[7:0];
        if (frame_start) begin
            byte_sel_next = 1'b0;
            underrun_next = 1'b0;
        end else if (pix_req) begin
            if (fifo_empty) begin
                underrun_next = 1'b1;
            end else if (mode_q == MODE_RGB565) begin
                pix_next = unpack_rgb565(fifo_head);
                fifo_pop = 1'b1;
            end else begin
                pix_next      = unpack_rgb332(cur_byte);
                fifo_pop      = byte_sel;
                byte_sel_next = !byte_sel;
            end
        end
    end

    // Pixel output register, byte selector and sticky underrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q    <= '0;
            byte_sel <= 1'b0;
            underrun <= 1'b0;
        end else begin
            pix_q    <= pix_next;
            byte_sel <= byte_sel_next;
            underrun <= underrun_next;
        end
    end

    assign red   = pix_q.r;
    assign green = pix_q.g;
    assign blue  = pix_q.b;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Self-checking bench for vga_fb_scanout: SRAM model with host-write merge,
// a frame-level pixel reference model, and randomized host/raster traffic.
module tb_vga_fb_scanout;

    localparam int H      = 800;
    localparam int V      = 2;
    localparam int AW     = 19;
    localparam int DEPTH  = 16;
    localparam int FRAME_PIXELS = H * V;

    logic          clk;
    logic          rst;
    logic          frame_start;
    logic          pix_req;
    logic          mode;
    logic [AW-1:0] fb_base;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [1:0]    wr_be;
    logic          sram_re;
    logic          sram_we;
    logic [1:0]    sram_be;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_wdata;
    logic [15:0]   sram_rdata;
    logic [3:0]    red;
    logic [3:0]    green;
    logic [3:0]    blue;
    logic          underrun;

    vga_fb_scanout #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .ADDR_W     (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_req     (pix_req),
        .mode        (mode),
        .fb_base     (fb_base),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_be       (wr_be),
        .sram_re     (sram_re),
        .sram_we     (sram_we),
        .sram_be     (sram_be),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SRAM model: unwritten words read back their address
    logic [15:0] ov [int];
    logic [15:0] wr_merge;

    function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
        if (ov.exists(int'(a))) return ov[int'(a)];
        return a[15:0];
    endfunction

    always @(posedge clk) begin
        if (sram_re) sram_rdata <= mem_word(sram_addr);
        if (sram_we) begin
            wr_merge = mem_word(sram_addr);
            if (sram_be[0]) wr_merge[7:0]  = sram_wdata[7:0];
            if (sram_be[1]) wr_merge[15:8] = sram_wdata[15:8];
            ov[int'(sram_addr)] = wr_merge;
        end
    end

    // ---------------- checking
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state
    logic          frame_seen = 1'b0;
    int            frame_pixels = 0;
    int            pix_idx = 0;
    logic [AW-1:0] frame_base = '0;
    logic          frame_mode = 1'b0;
    logic          exp_underrun = 1'b0;
    logic [AW-1:0] rd_log [$];
    int            wr_grants = 0;
    int            prio_window = 0;
    logic          want_grant = 1'b0;

    // Pixel k of the current frame, from plain arithmetic on the stored word
    function automatic logic [11:0] model_pixel(input logic [AW-1:0] base, input logic md, input int k);
        int w, b, r, g, bl;
        if (md) begin
            w  = int'(mem_word(base + AW'(k)));
            r  = w / 4096;
            g  = (w / 128) % 16;
            bl = (w / 2) % 16;
        end else begin
            w  = int'(mem_word(base + AW'(k / 2)));
            b  = (k % 2 == 1) ? (w / 256) : (w % 256);
            r  = (b / 32) * 2 + (b / 32) / 4;
            g  = ((b / 4) % 8) * 2 + ((b / 4) % 8) / 4;
            bl = (b % 4) * 4 + (b % 4);
        end
        return 12'(r * 256 + g * 16 + bl);
    endfunction

    // One clock cycle with the inputs currently driven; checks port
    // behaviour before the edge and the registered pixel after it.
    task automatic cycle();
        logic          c_fs, c_pix, c_rst, c_mode;
        logic [AW-1:0] c_base;
        logic [11:0]   exp_rgb;
        c_fs = frame_start; c_pix = pix_req; c_rst = rst;
        c_mode = mode; c_base = fb_base;
        #2;
        check("we_is_ready", sram_we, wr_ready);
        check("single_op", sram_re & sram_we, 0);
        if (wr_ready) begin
            wr_grants++;
            check("wr_valid_on_grant", wr_valid, 1);
            check("wr_addr_pass", sram_addr, wr_addr);
            check("wr_data_pass", sram_wdata, wr_data);
            check("wr_be_pass", sram_be, wr_be);
        end
        if (c_fs || c_rst) check("no_read_on_fs_rst", sram_re, 0);
        if (!frame_seen)   check("no_read_before_frame", sram_re, 0);
        if (want_grant)    check("wr_grant_idle", wr_ready, 1);
        if (prio_window > 0) begin
            check("read_prio_ready_low", wr_ready, 0);
            check("read_prio_re", sram_re, 1);
            prio_window--;
        end
        if (sram_re) rd_log.push_back(sram_addr);
        @(negedge clk);
        exp_rgb = 12'h000;
        if (c_rst) begin
            frame_seen = 1'b0; frame_pixels = 0; pix_idx = 0; exp_underrun = 1'b0;
            rd_log.delete();
        end else if (c_fs) begin
            frame_seen = 1'b1; frame_pixels = FRAME_PIXELS; pix_idx = 0;
            frame_base = c_base; frame_mode = c_mode; exp_underrun = 1'b0;
            rd_log.delete();
        end else if (c_pix) begin
            if (pix_idx < frame_pixels) begin
                exp_rgb = model_pixel(frame_base, frame_mode, pix_idx);
                pix_idx++;
            end else begin
                exp_underrun = 1'b1;
            end
        end
        check("rgb", {red, green, blue}, exp_rgb);
        check("underrun", underrun, exp_underrun);
    endtask

    task automatic set_idle();
        rst = 1'b0; frame_start = 1'b0; pix_req = 1'b0; wr_valid = 1'b0;
    endtask

    task automatic rand_write();
        wr_addr = AW'(32'h40000 | $urandom_range(0, 32'hFFFF));
        wr_data = 16'($urandom);
        wr_be   = 2'($urandom_range(1, 3));
    endtask

    task automatic start_frame(input logic md, input logic [AW-1:0] base);
        frame_start = 1'b1; mode = md; fb_base = base;
        cycle();
        frame_start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_idle();
        rst = 1'b1; mode = 1'b0; fb_base = '0;
        wr_addr = '0; wr_data = '0; wr_be = 2'b00;
        @(negedge clk);
        repeat (3) cycle();
        rst = 1'b0;

        // Reset state: idle port, nothing requested
        #2;
        check("rst_sram_re", sram_re, 0);
        check("rst_sram_we", sram_we, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_wr_ready", wr_ready, 0);
        cycle();

        // Host writes are granted immediately after reset
        want_grant = 1'b1;
        wr_valid = 1'b1; wr_addr = 19'h02000; wr_data = 16'hE01C; wr_be = 2'b11;
        cycle();
        wr_addr = 19'h02001; wr_data = 16'hABCD; wr_be = 2'b01;
        cycle();
        want_grant = 1'b0;
        wr_valid = 1'b0;
        cycle();

        // Mode 1 at 0x100: exactly FIFO_DEPTH sequential reads, then stream
        start_frame(1'b1, 19'h00100);
        repeat (30) cycle();
        check("fill_reads", rd_log.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) check("fill_addr", rd_log[i], 19'h00100 + AW'(i));
        pix_req = 1'b1;
        repeat (200) cycle();
        pix_req = 1'b0;

        // Mode 0 at 0x2000 (0xE01C first), run the whole frame dry, underrun
        start_frame(1'b0, 19'h02000);
        repeat (20) cycle();
        pix_req = 1'b1;
        repeat (FRAME_PIXELS) cycle();
        check("m0_frame_reads", rd_log.size(), FRAME_PIXELS / 2);
        repeat (4) cycle();
        check("underrun_seen", underrun, 1);
        pix_req = 1'b1;
        start_frame(1'b1, 19'h03000);   // coincident pix_req: frame_start wins
        check("underrun_cleared", underrun, 0);

        // Continuous host writes across a full line in mode 1
        wr_valid = 1'b1; rand_write();
        pix_req = 1'b0;
        start_frame(1'b1, AW'($urandom_range(32'h1000, 32'h30000)));
        prio_window = 8;
        for (int i = 0; i < 20; i++) begin rand_write(); cycle(); end
        wr_grants = 0;
        pix_req = 1'b1;
        for (int i = 0; i < H; i++) begin rand_write(); cycle(); end
        check("line_writes_granted", (wr_grants > 0), 1);
        check("line_no_underrun", underrun, 0);
        pix_req = 1'b0; wr_valid = 1'b0;

        // Randomized raster and host traffic
        start_frame(1'($urandom_range(0, 1)), AW'($urandom_range(32'h1000, 32'h30000)));
        for (int i = 0; i < 20; i++) begin
            wr_valid = 1'($urandom_range(0, 1)); rand_write(); cycle();
        end
        for (int i = 0; i < 500; i++) begin
            pix_req  = ($urandom_range(0, 3) != 0);
            wr_valid = 1'($urandom_range(0, 1));
            rand_write();
            cycle();
        end

        // Reset mid-line with reads in flight, then a request with no frame
        pix_req = 1'b1; wr_valid = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0; pix_req = 1'b0;
        cycle();
        pix_req = 1'b1;
        cycle();
        pix_req = 1'b0;
        cycle();

        // Address wrap at the top of SRAM; no stale data after the reset
        start_frame(1'b1, 19'h7FFFE);
        repeat (20) cycle();
        check("wrap_addr0", rd_log[0], 19'h7FFFE);
        check("wrap_addr1", rd_log[1], 19'h7FFFF);
        check("wrap_addr2", rd_log[2], 19'h00000);
        pix_req = 1'b1;
        repeat (60) cycle();
        pix_req = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_fb_scanout.md
# vga_fb_scanout

Parametrised framebuffer scanout engine sitting between the VGA timing generator and the external 16-bit SRAM. It prefetches framebuffer words into a small FIFO ahead of the raster, unpacks them into 4-bit-per-channel RGB in 8 bpp (RGB332) or 16 bpp (RGB565) mode, and arbitrates the single SRAM port between display reads and a host write port. It replaces direct per-pixel address computation with linear prefetch, so the SRAM sees back-to-back sequential reads with no per-pixel multiply.

## Interface
- H_ACTIVE, 800, visible pixels per line
- V_ACTIVE, 600, visible lines per frame
- ADDR_W, 19, SRAM word address width
- FIFO_DEPTH, 16, prefetch FIFO depth in 16-bit words (power of 2, ≥4)
- clk  in  1  pixel/system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- pix_req  in  1  high for each active-zone pixel; one pixel consumed per cycle
- mode  in  1  0 = 8 bpp RGB332, 1 = 16 bpp RGB565; sampled on frame_start
- fb_base  in  ADDR_W  first word of frame; sampled on frame_start
- wr_valid  in  1  host write request
- wr_ready  out  1  host write accepted this cycle
- wr_addr  in  ADDR_W  host write word address
- wr_data  in  16  host write data
- wr_be  in  2  byte enables {upper, lower}
- sram_re  out  1  read strobe
- sram_we  out  1  write strobe
- sram_be  out  2  byte enables
- sram_addr  out  ADDR_W  word address
- sram_wdata  out  16  write data
- sram_rdata  in  16  read data, valid one cycle after sram_re
- red, green, blue  out  4 each  pixel colour
- underrun  out  1  sticky: pixel requested while FIFO empty

## Operation
- Frame words: H_ACTIVE*V_ACTIVE/2 (mode 0) or H_ACTIVE*V_ACTIVE (mode 1); counter `words_left` loaded on frame_start.
- frame_start: flush FIFO, discard in-flight read data, load read address = fb_base, latch mode, clear underrun, reset byte selector to low byte.
- Read eligible when words_left > 0 and FIFO level + in-flight < FIFO_DEPTH.
- Arbitration per cycle: level < FIFO_DEPTH/2 → read wins; else wr_valid → write wins; else read if eligible. At most one SRAM op per cycle; wr_ready high exactly on write-grant cycles.
- Read address increments by 1 per issued read, wraps modulo 2^ADDR_W.
- Unpack, mode 0: low byte first, then high byte; FIFO popped after the high byte. Byte b: R={b[7:5],b[7]}, G={b[4:2],b[4]}, B={b[1:0],b[1:0]}.
- Unpack, mode 1: pop every pixel; R=w[15:12], G=w[10:7], B=w[4:1].
- pix_req with FIFO empty: output 0,0,0, set underrun, do not pop; byte selector unchanged.
- pix_req low: RGB outputs 0 next cycle.
- Reset values: all outputs 0, underrun 0, FIFO empty, words_left 0. After reset no reads issue until the first frame_start; host writes are granted immediately.

## Timing
- sram_re at cycle N → sram_rdata captured into FIFO at end of N+1 (unless frame_start in N or N+1).
- pix_req at N → RGB registered at N+1.
- frame_start coincident with pix_req: frame_start wins, pixel outputs 0, no pop.
- frame_start coincident with a read issue: the read is suppressed; the first new-frame read issues at N+1.
- Write: wr_valid && wr_ready at N → sram_we/addr/wdata/be driven in the same cycle N (combinational pass-through of the granted request), then deasserted.
- Reset mid-frame: everything returns to reset values at the next edge; in-flight data is dropped.

## Structure
- Package vga_fb_pkg: mode constants (MODE_RGB332, MODE_RGB565), default parameter values, unpack/expansion functions.
- Sub-module fb_prefetch_fifo: synchronous show-ahead FIFO with flush, level output, and FIFO_DEPTH/width parameters.
- Top-level holds arbiter, address/word counters, in-flight tracking, and pixel unpack register.

## Test plan
- Reset, frame_start, fb_base=0x100, mode 1, memory word = address → first 16 reads at 0x100..0x10F; pix_req stream yields R/G/B of w=0x0100, 0x0101, … in order.
- Mode 0, word 0xE01C → two pixels: (R=0,G=0xF,B=0) from low byte 0x1C, then (R=0xF,G=0,B=0) from high byte 0xE0; one pop.
- Continuous wr_valid with FIFO ≥ half full → writes granted and the FIFO never underruns over a full 800-pixel line; wr_ready is low on read-priority cycles.
- Hold sram_rdata path stalled (no frame_start, words_left=0 early via tiny H/V) then pix_req → RGB 0 and underrun=1; next frame_start clears it.
- fb_base = 2^ADDR_W−2, mode 1 → read addresses 0x7FFFE, 0x7FFFF, 0x00000.
- Assert rst mid-line with reads in flight → all outputs 0 next cycle, no stale word appears after the following frame_start.
